// File: rtl/gcd_lcm_if.sv
// Request/result handshake bundle for the GCD/LCM coprocessor.
// The master issues requests and consumes results; the slave is the engine.
interface gcd_lcm_if #(
   parameter int W = 16
);
   logic           start;
   logic           mode;
   logic [W-1:0]   A_in;
   logic [W-1:0]   B_in;
   logic           busy;
   logic [2*W-1:0] result;
   logic           result_valid;
   logic           result_ready;

   modport master (
      output start, mode, A_in, B_in, result_ready,
      input  busy, result, result_valid
   );

   modport slave (
      input  start, mode, A_in, B_in, result_ready,
      output busy, result, result_valid
   );
endinterface

// File: rtl/gcd_lcm_unit.sv
// Binary (Stein) GCD engine with an LCM mode: lcm = (a/gcd)*b computed
// with a serial restoring divide followed by a serial shift-add multiply.
module gcd_lcm_unit #(
   parameter int W = 16
) (
   input  logic      clk,
   input  logic      rst,
   gcd_lcm_if.slave  io
);
   localparam int DW = $clog2(W) + 1;

   typedef enum logic [2:0] {
      IDLE, REDUCE, SHIFT, DIV, MUL, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   a0_q, a0_d;
   logic [W-1:0]   b0_q, b0_d;
   logic           m_q, m_d;
   logic [DW-1:0]  d_q, d_d;
   logic [DW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   g_q, g_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [2*W-1:0] result_q, result_d;
   logic           busy_q, busy_d;
   logic           valid_q, valid_d;

   logic [W:0]     rem_t;
   logic [W-1:0]   g_t;
   logic           ev_a, ev_b;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      a0_d     = a0_q;
      b0_d     = b0_q;
      m_d      = m_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
      g_d      = g_q;
      q_d      = q_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      result_d = result_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      rem_t    = {rem_q, q_q[W-1]};
      g_t      = a_q << d_q;
      ev_a     = ~a_q[0];
      ev_b     = ~b_q[0];

      unique case (state_q)
         IDLE: begin
            if (io.start && !valid_q) begin
               a0_d   = io.A_in;
               b0_d   = io.B_in;
               m_d    = io.mode;
               a_d    = io.A_in;
               b_d    = io.B_in;
               d_d    = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (io.A_in == '0 || io.B_in == '0) begin
                  // gcd(0,x)=x, and any LCM with a zero operand is zero
                  acc_d   = io.mode ? '0 : {{W{1'b0}}, io.A_in | io.B_in};
                  state_d = DONE;
               end else begin
                  state_d = REDUCE;
               end
            end
         end
         REDUCE: begin
            unique case (1'b1)
               (ev_a && ev_b): begin
                  a_d = a_q >> 1;
                  b_d = b_q >> 1;
                  d_d = d_q + DW'(1);
               end
               (ev_a && !ev_b): a_d = a_q >> 1;
               (!ev_a && ev_b): b_d = b_q >> 1;
               (!ev_a && !ev_b && a_q > b_q): a_d = a_q - b_q;
               (!ev_a && !ev_b && a_q < b_q): b_d = b_q - a_q;
               (!ev_a && !ev_b && a_q == b_q): state_d = SHIFT;
            endcase
         end
         SHIFT: begin
            if (m_q) begin
               g_d     = g_t;
               q_d     = a0_q;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = DIV;
            end else begin
               acc_d   = {{W{1'b0}}, g_t};
               state_d = DONE;
            end
         end
         DIV: begin
            // q_q shifts the dividend out and the quotient in
            if (rem_t >= {1'b0, g_q}) begin
               rem_d = W'(rem_t - {1'b0, g_q});
               q_d   = {q_q[W-2:0], 1'b1};
            end else begin
               rem_d = rem_t[W-1:0];
               q_d   = {q_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + DW'(1);
            if (cnt_q == DW'(W - 1)) begin
               cnt_d   = '0;
               acc_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d = {acc_q[2*W-2:0], 1'b0}
                  + (q_q[W-1] ? {{W{1'b0}}, b0_q} : '0);
            q_d   = q_q << 1;
            cnt_d = cnt_q + DW'(1);
            if (cnt_q == DW'(W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!valid_q) begin
               result_d = acc_q;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
            end else if (io.result_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         a0_q     <= '0;
         b0_q     <= '0;
         m_q      <= 1'b0;
         d_q      <= '0;
         cnt_q    <= '0;
         g_q      <= '0;
         q_q      <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a0_q     <= a0_d;
         b0_q     <= b0_d;
         m_q      <= m_d;
         d_q      <= d_d;
         cnt_q    <= cnt_d;
         g_q      <= g_d;
         q_q      <= q_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
      end
   end

   assign io.busy         = busy_q;
   assign io.result       = result_q;
   assign io.result_valid = valid_q;
endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Self-checking bench for gcd_lcm_unit: scoreboard of expected results
// and latencies against a Euclid-based golden model.
module tb_gcd_lcm_unit;
   localparam int W = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [2*W-1:0] exp_q[$];
   int             lat_q[$];

   gcd_lcm_if #(.W(W)) bus ();

   gcd_lcm_unit #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] euclid(logic [W-1:0] a, logic [W-1:0] b);
      logic [W-1:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic logic [2*W-1:0] gold(logic [W-1:0] a, logic [W-1:0] b,
                                           logic md);
      logic [W-1:0] g;
      logic [63:0]  l;
      if (a == 0 || b == 0) return md ? '0 : {{W{1'b0}}, a | b};
      g = euclid(a, b);
      l = 64'(a / g) * 64'(b);
      return md ? l[2*W-1:0] : {{W{1'b0}}, g};
   endfunction

   function automatic int stein_steps(logic [W-1:0] a, logic [W-1:0] b);
      int n = 0;
      while (n < 1000) begin
         n++;
         if (!a[0] && !b[0]) begin a = a >> 1; b = b >> 1; end
         else if (!a[0]) a = a >> 1;
         else if (!b[0]) b = b >> 1;
         else if (a > b) a = a - b;
         else if (a < b) b = b - a;
         else break;
      end
      return n;
   endfunction

   function automatic int exp_lat(logic [W-1:0] a, logic [W-1:0] b, logic md);
      if (a == 0 || b == 0) return 2;
      return 3 + stein_steps(a, b) + (md ? 2 * W : 0);
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic md);
      int n = 0;
      @(negedge clk);
      while ((bus.busy || bus.result_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      bus.start = 1'b1;
      bus.mode  = md;
      bus.A_in  = a;
      bus.B_in  = b;
      exp_q.push_back(gold(a, b, md));
      lat_q.push_back(exp_lat(a, b, md));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(output int lat, output bit to);
      lat = 1;
      while (!bus.result_valid && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
      to = !bus.result_valid;
   endtask

   task automatic ack();
      @(negedge clk);
      bus.result_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b valid=%b required 0 0",
                  bus.busy, bus.result_valid);
      end
      checks++;
      if (bus.result !== '0) begin
         errors++;
         $display("FAIL reset_result got %0d required 0", bus.result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_gcd();
      int lat;
      bit to;
      logic [2*W-1:0] e;
      int el;
      issue(16'd48, 16'd18, 1'b0);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL gcd_busy got %b required 1", bus.busy);
      end
      wait_valid(lat, to);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      checks++;
      if (to || bus.result !== e) begin
         errors++;
         $display("FAIL gcd_48_18 got %0d required %0d", bus.result, e);
      end
      checks++;
      if (lat !== el) begin
         errors++;
         $display("FAIL gcd_latency got %0d required %0d", lat, el);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== e || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL gcd_hold valid=%b res=%0d busy=%b required 1 %0d 0",
                  bus.result_valid, bus.result, bus.busy, e);
      end
      ack();
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL gcd_release valid=%b busy=%b required 0 0",
                  bus.result_valid, bus.busy);
      end
   endtask

   task automatic run_table(input string nm, input logic [W-1:0] av[],
                            input logic [W-1:0] bv[], input logic mv[]);
      int lat;
      bit to;
      logic [2*W-1:0] e;
      int el;
      int steps;
      for (int i = 0; i < av.size(); i++) begin
         issue(av[i], bv[i], mv[i]);
         wait_valid(lat, to);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         checks++;
         if (to || bus.result !== e) begin
            errors++;
            $display("FAIL %s_res a=%0d b=%0d m=%0d got %0d required %0d",
                     nm, av[i], bv[i], mv[i], bus.result, e);
         end
         checks++;
         if (lat !== el) begin
            errors++;
            $display("FAIL %s_lat a=%0d b=%0d got %0d required %0d",
                     nm, av[i], bv[i], lat, el);
         end
         steps = stein_steps(av[i], bv[i]);
         checks++;
         if (av[i] != 0 && bv[i] != 0
             && lat - 3 - (mv[i] ? 2 * W : 0) > 4 * W) begin
            errors++;
            $display("FAIL %s_bound reduce=%0d required <=%0d model=%0d",
                     nm, lat - 3 - (mv[i] ? 2 * W : 0), 4 * W, steps);
         end
         ack();
      end
   endtask

   task automatic test_lcm();
      logic [W-1:0] av[] = '{16'd4, 16'd21, 16'd65535};
      logic [W-1:0] bv[] = '{16'd6, 16'd6, 16'd65534};
      logic         mv[] = '{1'b1, 1'b1, 1'b1};
      run_table("lcm", av, bv, mv);
   endtask

   task automatic test_zero();
      logic [W-1:0] av[] = '{16'd0, 16'd0, 16'd0, 16'd7};
      logic [W-1:0] bv[] = '{16'd0, 16'd35, 16'd5, 16'd0};
      logic         mv[] = '{1'b0, 1'b0, 1'b1, 1'b0};
      run_table("zero", av, bv, mv);
   endtask

   task automatic test_extremes();
      logic [W-1:0] av[] = '{16'd65535, 16'd32768, 16'd1, 16'd65535};
      logic [W-1:0] bv[] = '{16'd65534, 16'd32768, 16'd65535, 16'd65535};
      logic         mv[] = '{1'b0, 1'b0, 1'b1, 1'b1};
      run_table("ext", av, bv, mv);
   endtask

   task automatic test_backpressure();
      int lat;
      bit to;
      logic [2*W-1:0] e;
      issue(16'd48, 16'd18, 1'b0);
      wait_valid(lat, to);
      e = exp_q.pop_front();
      void'(lat_q.pop_front());
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.mode  = 1'($urandom_range(0, 1));
         bus.A_in  = W'($urandom_range(1, 65535));
         bus.B_in  = W'($urandom_range(1, 65535));
         @(posedge clk);
         #1;
         checks++;
         if (to || bus.result_valid !== 1'b1 || bus.result !== e
             || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d valid=%b res=%0d busy=%b required 1 %0d 0",
                     i, bus.result_valid, bus.result, bus.busy, e);
         end
      end
      @(negedge clk);
      bus.result_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.result_ready = 1'b0;
      checks++;
      if (bus.result_valid !== 1'b0 || bus.result !== e) begin
         errors++;
         $display("FAIL bp_drop valid=%b res=%0d required 0 %0d",
                  bus.result_valid, bus.result, e);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_accept busy=%b valid=%b required 0 0",
                  bus.busy, bus.result_valid);
      end
   endtask

   task automatic reset_pulse(input string nm);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.result !== '0) begin
         errors++;
         $display("FAIL %s busy=%b valid=%b res=%0d required 0 0 0",
                  nm, bus.busy, bus.result_valid, bus.result);
      end
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit to;
      logic [2*W-1:0] e;
      issue(16'd48, 16'd18, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_reduce_pre busy=%b required 1", bus.busy);
      end
      reset_pulse("rst_reduce");
      issue(16'd21, 16'd6, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mul_pre busy=%b required 1", bus.busy);
      end
      reset_pulse("rst_mul");
      issue(16'd100, 16'd75, 1'b0);
      wait_valid(lat, to);
      e = exp_q.pop_front();
      void'(lat_q.pop_front());
      checks++;
      if (to || bus.result !== e) begin
         errors++;
         $display("FAIL rst_after got %0d required %0d", bus.result, e);
      end
      ack();
   endtask

   task automatic test_back_to_back();
      int lat;
      bit to;
      logic [2*W-1:0] e;
      int el;
      logic [W-1:0] av[] = '{16'd12, 16'd9, 16'd1000, 16'd7};
      logic [W-1:0] bv[] = '{16'd8, 16'd0, 16'd250, 16'd13};
      logic         mv[] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bus.result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(av[i], bv[i], mv[i]);
         wait_valid(lat, to);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         checks++;
         if (to || bus.result !== e || lat !== el) begin
            errors++;
            $display("FAIL b2b%0d res=%0d lat=%0d required %0d %0d",
                     i, bus.result, lat, e, el);
         end
      end
      @(posedge clk);
      #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic test_random();
      int lat;
      bit to;
      logic [2*W-1:0] e;
      int el;
      logic [W-1:0] a, b;
      int bad = 0;
      for (int i = 0; i < 500; i++) begin
         a = W'($urandom) & W'((1 << $urandom_range(1, W)) - 1);
         b = W'($urandom) & W'((1 << $urandom_range(1, W)) - 1);
         issue(a, b, 1'($urandom_range(0, 1)));
         wait_valid(lat, to);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         checks++;
         if (to || bus.result !== e || lat !== el) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL rand a=%0d b=%0d m=%0d res=%0d lat=%0d required %0d %0d",
                        a, b, bus.mode, bus.result, lat, e, el);
         end
         ack();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.A_in = '0;
      bus.B_in = '0;
      bus.result_ready = 1'b0;
      test_reset();
      test_gcd();
      test_lcm();
      test_zero();
      test_extremes();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
